alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter that shares one combinational ALU between two issue slots of the superscalar pipeline. It muxes the winning slot's operands and 4-bit ALU control code (codes from `menu.vh`) onto the ALU inputs. It registers the ALU result and zero flag into a one-entry output buffer tagged with the slot and destination tag. It sits between issue and writeback/branch-resolve, with valid/ready handshakes on both sides.

## Interface
- `TAG_W`, default 5: width of the destination tag (register index) carried with each op.
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` input 1 each: slot 0/1 has an op.
- `req0_ready` / `req1_ready` output 1 each: slot 0/1 op accepted this cycle.
- `req0_data_1`, `req0_data_2`, `req1_data_1`, `req1_data_2` input `WORD`: operands.
- `req0_control`, `req1_control` input 4: ALU control code.
- `req0_tag`, `req1_tag` input TAG_W: destination tag.
- `alu_data_1`, `alu_data_2` output `WORD`: to ALU operand inputs.
- `alu_control` output 4: to ALU control input.
- `alu_result` input `WORD`, `alu_flag` input 1: from ALU, combinational in the same cycle.
- `out_valid` output 1: output buffer holds a result.
- `out_ready` input 1: consumer takes the result this cycle.
- `out_result` output `WORD`, `out_zero` output 1, `out_slot` output 1, `out_tag` output TAG_W: buffered result, zero flag, originating slot, tag.

## Operation
- Output buffer has two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `can_issue` = EMPTY, or FULL with `out_ready`=1 (drain and refill in the same cycle).
- Round-robin pointer `rr` (1 bit) names the slot with priority this cycle.
- Grant:
  - Only one slot requests: that slot wins.
  - Both request: slot `rr` wins.
  - No request: nothing is granted and the ALU inputs are driven to 0.
- `reqN_ready` = `can_issue` AND slot N won. This is combinational and never asserted for the losing slot.
- ALU inputs are always driven from the current winner. When there is no winner they are 0 with control 0.
- Accept (`reqN_valid` & `reqN_ready`):
  - Buffer loads `alu_result`, `alu_flag`, slot N and `reqN_tag`.
  - Buffer goes to or stays FULL.
  - `rr` becomes `~N`.
- Drain without accept: buffer goes to EMPTY. Data fields hold their last values.
- FULL and `out_ready`=0: no grant, and `rr` and the buffer hold.
- `rr` changes only on an accept.
- Width: operands and result are `WORD` bits. Wrap-around arithmetic is the ALU's concern; the arbiter passes values unmodified.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `out_zero`=0, `out_slot`=0, `out_tag`=0, `rr`=0 (slot 0 favoured first).
- `reqN_ready`=0 during the reset cycle, regardless of inputs.
- Latency: an op accepted at edge k is visible on `out_*` with `out_valid`=1 after edge k, i.e. 1 cycle.
- Throughput: 1 op per cycle when `out_ready` is held high.
- Reset asserted while FULL: the buffer is discarded and `out_valid`=0 on the next cycle. A request held across reset is accepted only after reset deasserts.
- Requesters must hold valid, operands and tag stable until ready. A requester may deassert valid without being accepted; nothing is lost.
- A simultaneous drain and accept produces no bubble.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: slot 0 always wins when both request. `rr` is not implemented, and slot 1 can starve.
  - Undefined: round-robin as above.

## Test plan
- Reset, then slot 0 only: data_1=5, data_2=3, control=`alu_add`, tag=7, `out_ready`=1 -> `req0_ready`=1 the same cycle; next cycle `out_valid`=1, `out_result`=8, `out_zero`=0, `out_slot`=0, `out_tag`=7.
- Both slots valid for 4 cycles with `out_ready`=1 -> grants go 0,1,0,1 and `out_slot` follows 0,1,0,1 one cycle later. With `ALU_ARB_FIXED_PRIO_EN` defined: 0,0,0,0.
- Backpressure: buffer FULL, `out_ready`=0 for 3 cycles, both slots requesting -> both readies 0, `out_*` stable, `rr` unchanged. Then `out_ready`=1 -> grant to the `rr` slot and the result is replaced with no bubble.
- Zero flag: slot 1 `alu_sub` with 9, 9 -> `out_result`=0, `out_zero`=1. Slot 1 `alu_cbz` with data_2=0x10 -> `out_result`=0x10, `out_zero`=0.
- Reset asserted while FULL with slot 0 requesting -> the next cycle has `out_valid`=0 and `req0_ready`=0. After deassert, slot 0 is accepted first.
- Idle: no requests -> `alu_data_1`=0, `alu_data_2`=0, `alu_control`=0, `rr` unchanged, `out_valid` falls after a drain.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two issue slots and buffers the result in a one-entry output stage.
// Define ALU_ARB_FIXED_PRIO_EN to make slot 0 always win ties (no round-robin pointer).
module alu_share_arbiter #(
   parameter int TAG_W  = 5,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   // Handshake (both sides): a transfer happens on a rising edge where valid and ready are both 1;
   // a requester holds valid, operands and tag stable until ready and may withdraw while not accepted.
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [WORD_W-1:0] req0_data_1,
   input  logic [WORD_W-1:0] req0_data_2,
   input  logic [3:0]        req0_control,
   input  logic [TAG_W-1:0]  req0_tag,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [WORD_W-1:0] req1_data_1,
   input  logic [WORD_W-1:0] req1_data_2,
   input  logic [3:0]        req1_control,
   input  logic [TAG_W-1:0]  req1_tag,
   output logic [WORD_W-1:0] alu_data_1,
   output logic [WORD_W-1:0] alu_data_2,
   output logic [3:0]        alu_control,
   input  logic [WORD_W-1:0] alu_result,
   input  logic              alu_flag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_slot,
   output logic [TAG_W-1:0]  out_tag,
   output logic              debug_state,
   output logic              debug_rr
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   buf_state_t        state;
   buf_state_t        state_next;
   logic              rr;
   logic              can_issue;
   logic              win_valid;
   logic              win_slot;
   logic              grant;
   logic [WORD_W-1:0] res_q;
   logic              zero_q;
   logic              slot_q;
   logic [TAG_W-1:0]  tag_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign rr = 1'b0;
`else
   // The pointer moves only on an accept, always to the slot that did not just win.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr <= 1'b0;
      end else if (grant) begin
         rr <= ~win_slot;
      end
   end
`endif

   always_comb begin
      win_valid = req0_valid | req1_valid;
      win_slot  = 1'b0;
      if (req0_valid && req1_valid) begin
         win_slot = rr;
      end else if (req1_valid) begin
         win_slot = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      can_issue  = 1'b0;
      case (state)
         EMPTY:   can_issue = 1'b1;
         FULL:    can_issue = out_ready;
         default: can_issue = 1'b0;
      endcase
      if (reset) begin
         can_issue = 1'b0;
      end
      grant = can_issue & win_valid;
      if (grant) begin
         state_next = FULL;
      end else if ((state == FULL) && out_ready) begin
         state_next = EMPTY;
      end
   end

   always_comb begin
      req0_ready  = grant & ~win_slot;
      req1_ready  = grant & win_slot;
      alu_data_1  = '0;
      alu_data_2  = '0;
      alu_control = 4'd0;
      if (grant) begin
         if (win_slot) begin
            alu_data_1  = req1_data_1;
            alu_data_2  = req1_data_2;
            alu_control = req1_control;
         end else begin
            alu_data_1  = req0_data_1;
            alu_data_2  = req0_data_2;
            alu_control = req0_control;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Data fields load only on accept; a plain drain leaves the last values visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_q  <= '0;
         zero_q <= 1'b0;
         slot_q <= 1'b0;
         tag_q  <= '0;
      end else if (grant) begin
         res_q  <= alu_result;
         zero_q <= alu_flag;
         slot_q <= win_slot;
         tag_q  <= win_slot ? req1_tag : req0_tag;
      end
   end

   assign out_valid   = (state == FULL);
   assign out_result  = res_q;
   assign out_zero    = zero_q;
   assign out_slot    = slot_q;
   assign out_tag     = tag_q;
   assign debug_state = state;
   assign debug_rr    = rr;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors, a spec-level reference model checked every cycle,
// and literal expectations from the test plan.
module tb_alu_share_arbiter;

   localparam int TAG_W = 5;
   localparam int W     = 32;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_CBZ = 4'b0111;

   logic             clk;
   logic             reset;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [W-1:0]     req0_data_1, req0_data_2, req1_data_1, req1_data_2;
   logic [3:0]       req0_control, req1_control;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic [W-1:0]     alu_data_1, alu_data_2;
   logic [3:0]       alu_control;
   logic [W-1:0]     alu_result;
   logic             alu_flag;
   logic             out_valid, out_ready;
   logic [W-1:0]     out_result;
   logic             out_zero, out_slot;
   logic [TAG_W-1:0] out_tag;
   logic             debug_state, debug_rr;

   int checks = 0;
   int passes = 0;

   alu_share_arbiter #(.TAG_W(TAG_W), .WORD_W(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_data_1(req0_data_1), .req0_data_2(req0_data_2),
      .req0_control(req0_control), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_data_1(req1_data_1), .req1_data_2(req1_data_2),
      .req1_control(req1_control), .req1_tag(req1_tag),
      .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_control(alu_control),
      .alu_result(alu_result), .alu_flag(alu_flag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_slot(out_slot), .out_tag(out_tag),
      .debug_state(debug_state), .debug_rr(debug_rr)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- environment ALU ----------------
   function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      case (c)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_CBZ: return b;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_fn(alu_control, alu_data_1, alu_data_2);
      alu_flag   = (alu_result == '0);
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   logic             m_on = 1'b0;
   logic             m_valid, m_zero, m_slot, m_rr;
   logic [W-1:0]     m_res;
   logic [TAG_W-1:0] m_tag;
   int               c_win;
   logic [W-1:0]     e_d1, e_d2, e_r;
   logic [3:0]       e_c;

   always @(negedge clk) begin
      if (reset) begin
         check("m_rdy0_rst", {31'd0, req0_ready}, 0);
         check("m_rdy1_rst", {31'd0, req1_ready}, 0);
         m_valid = 1'b0; m_res = '0; m_zero = 1'b0; m_slot = 1'b0; m_tag = '0; m_rr = 1'b0;
         m_on    = 1'b1;
      end else if (m_on) begin
         check("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
         check("m_out_result", out_result, m_res);
         check("m_out_zero", {31'd0, out_zero}, {31'd0, m_zero});
         check("m_out_slot", {31'd0, out_slot}, {31'd0, m_slot});
         check("m_out_tag", {27'd0, out_tag}, {27'd0, m_tag});
         check("m_state", {31'd0, debug_state}, {31'd0, m_valid});
`ifndef ALU_ARB_FIXED_PRIO_EN
         check("m_rr", {31'd0, debug_rr}, {31'd0, m_rr});
`endif
         if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            c_win = 0;
`else
            c_win = m_rr ? 1 : 0;
`endif
         end else if (req0_valid) c_win = 0;
         else if (req1_valid) c_win = 1;
         else c_win = -1;
         if (m_valid && !out_ready) c_win = -1;
         check("m_rdy0", {31'd0, req0_ready}, (c_win == 0) ? 1 : 0);
         check("m_rdy1", {31'd0, req1_ready}, (c_win == 1) ? 1 : 0);
         e_d1 = '0; e_d2 = '0; e_c = 4'd0;
         if (c_win == 0) begin e_d1 = req0_data_1; e_d2 = req0_data_2; e_c = req0_control; end
         if (c_win == 1) begin e_d1 = req1_data_1; e_d2 = req1_data_2; e_c = req1_control; end
         check("m_alu_d1", alu_data_1, e_d1);
         check("m_alu_d2", alu_data_2, e_d2);
         check("m_alu_ctl", {28'd0, alu_control}, {28'd0, e_c});
         if (c_win >= 0) begin
            e_r     = alu_fn(e_c, e_d1, e_d2);
            m_valid = 1'b1;
            m_res   = e_r;
            m_zero  = (e_r == '0);
            m_slot  = (c_win == 1);
            m_tag   = (c_win == 1) ? req1_tag : req0_tag;
            m_rr    = (c_win == 0);
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c, input logic [TAG_W-1:0] t);
      req0_valid = v; req0_data_1 = a; req0_data_2 = b; req0_control = c; req0_tag = t;
   endtask

   task automatic set1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c, input logic [TAG_W-1:0] t);
      req1_valid = v; req1_data_1 = a; req1_data_2 = b; req1_control = c; req1_tag = t;
   endtask

   // ---------------- directed stimulus ----------------
`ifdef ALU_ARB_FIXED_PRIO_EN
   logic exp_g [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [W-1:0] HELD_RES  = 32'd23;
   localparam logic         HELD_SLOT = 1'b0;
`else
   logic exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   localparam logic [W-1:0] HELD_RES  = 32'd99;
   localparam logic         HELD_SLOT = 1'b1;
`endif

   initial begin
      reset = 1'b1; out_ready = 1'b0;
      set0(1'b0, 0, 0, 4'd0, 0);
      set1(1'b0, 0, 0, 4'd0, 0);
      step(); step();
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_tag", {27'd0, out_tag}, 0);
      reset = 1'b0;

      // single op from slot 0
      set0(1'b1, 5, 3, ALU_ADD, 7); out_ready = 1'b1;
      #1 check("t1_rdy0", {31'd0, req0_ready}, 1);
      step();
      set0(1'b0, 0, 0, 4'd0, 0);
      check("t1_valid", {31'd0, out_valid}, 1);
      check("t1_result", out_result, 8);
      check("t1_zero", {31'd0, out_zero}, 0);
      check("t1_slot", {31'd0, out_slot}, 0);
      check("t1_tag", {27'd0, out_tag}, 7);

      // alternating grants with both slots busy
      reset = 1'b1; step(); reset = 1'b0;
      set0(1'b1, 20, 3, ALU_ADD, 3);
      set1(1'b1, 100, 1, ALU_SUB, 4);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_rdy0", {31'd0, req0_ready}, {31'd0, ~exp_g[i]});
         check("t2_rdy1", {31'd0, req1_ready}, {31'd0, exp_g[i]});
         step();
         check("t2_slot", {31'd0, out_slot}, {31'd0, exp_g[i]});
         check("t2_result", out_result, exp_g[i] ? 32'd99 : 32'd23);
      end

      // backpressure holds everything
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t3_rdy0", {31'd0, req0_ready}, 0);
         check("t3_rdy1", {31'd0, req1_ready}, 0);
         check("t3_result", out_result, HELD_RES);
         check("t3_slot", {31'd0, out_slot}, {31'd0, HELD_SLOT});
         check("t3_rr", {31'd0, debug_rr}, 0);
         step();
      end
      out_ready = 1'b1;
      #1 check("t3_rdy0_go", {31'd0, req0_ready}, 1);
      step();
      check("t3_nobubble", {31'd0, out_valid}, 1);
      check("t3_new_slot", {31'd0, out_slot}, 0);
      check("t3_new_result", out_result, 23);
      set0(1'b0, 0, 0, 4'd0, 0);
      set1(1'b0, 0, 0, 4'd0, 0);

      // zero flag
      set1(1'b1, 9, 9, ALU_SUB, 9);
      #1 check("t4_rdy1", {31'd0, req1_ready}, 1);
      step();
      check("t4_sub_result", out_result, 0);
      check("t4_sub_zero", {31'd0, out_zero}, 1);
      check("t4_sub_tag", {27'd0, out_tag}, 9);
      set1(1'b1, 3, 32'h10, ALU_CBZ, 10);
      step();
      check("t4_cbz_result", out_result, 32'h10);
      check("t4_cbz_zero", {31'd0, out_zero}, 0);
      set1(1'b0, 0, 0, 4'd0, 0);

      // reset while full, both slots waiting
      set0(1'b1, 1, 1, ALU_ADD, 11);
      step();
      out_ready = 1'b0;
      set0(1'b1, 6, 8, ALU_OR, 12);
      set1(1'b1, 6, 3, ALU_AND, 13);
      reset = 1'b1;
      step();
      check("t5_valid_rst", {31'd0, out_valid}, 0);
      check("t5_rdy0_rst", {31'd0, req0_ready}, 0);
      step();
      reset = 1'b0;
      #1 check("t5_rdy0_after", {31'd0, req0_ready}, 1);
      check("t5_rdy1_after", {31'd0, req1_ready}, 0);
      step();
      check("t5_slot", {31'd0, out_slot}, 0);
      check("t5_result", out_result, 14);
      check("t5_tag", {27'd0, out_tag}, 12);
      out_ready = 1'b1;
      step();
      set0(1'b0, 0, 0, 4'd0, 0);
      set1(1'b0, 0, 0, 4'd0, 0);

      // idle: ALU inputs zero, buffer drains, pointer holds
      #1;
      check("t6_alu_d1", alu_data_1, 0);
      check("t6_alu_d2", alu_data_2, 0);
      check("t6_alu_ctl", {28'd0, alu_control}, 0);
      step();
      check("t6_drained", {31'd0, out_valid}, 0);
      check("t6_hold_result", out_result, 2);
      step();

      // empty buffer accepts even without out_ready
      out_ready = 1'b0;
      set1(1'b1, 40, 2, ALU_ADD, 21);
      #1 check("t7_rdy1", {31'd0, req1_ready}, 1);
      step();
      set1(1'b0, 0, 0, 4'd0, 0);
      check("t7_result", out_result, 42);
      out_ready = 1'b1;
      step(); step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
